compress_code_packer: RTL
=========================

Name: compress_code_packer

Overview:
- Downstream stage of the pattern comparators (zzzz/zzzx/dictionary match) in the compressor datapath.
- Accepts one variable-length code per beat, right-aligned with an explicit length.
  - Example: the 12-bit zzzx code {4'b1101, byte}.
  - Example: the 2-bit zzzz code 2'b00.
- Packs codes MSB-first into a contiguous bitstream.
- Emits fixed OUT_WIDTH-bit words over a valid/ready interface, with a flush that drains a final zero-padded partial word.

Parameters:
- OUT_WIDTH, 32, output word width in bits.
- MAX_CODE, 34, maximum code length in bits.
- LEN_W, 6, width of code_len_i; must satisfy 2^LEN_W > MAX_CODE.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- code_i  input  MAX_CODE  code value, right-aligned; bits at or above code_len_i are ignored (masked).
- code_len_i  input  LEN_W  code length, 0..MAX_CODE.
- in_valid_i  input  1  code beat valid.
- in_ready_o  output  1  packer accepts a beat this cycle.
- flush_i  input  1  request to drain the buffer and close the stream.
- out_data_o  output  OUT_WIDTH  packed word; first-arrived bit is in the MSB.
- out_valid_o  output  1  out_data_o valid.
- out_ready_i  input  1  downstream accepts the word.
- out_last_o  output  1  marks the final word of a flush.
- flush_done_o  output  1  one-cycle pulse when the flush completes.

Behaviour:
- Storage:
  - buf: BUF_W = OUT_WIDTH+MAX_CODE (66) bits, left-justified.
  - fill: count of valid bits, 0..BUF_W-1 (7 bits).
- Accept occurs when in_valid_i && in_ready_o.
  - The masked code is placed at buf bits [BUF_W-1-fill' -: code_len], where fill' is fill after any same-cycle emit shift.
  - fill increases by code_len.
  - code_len 0 is accepted with no effect.
- Emit occurs when out_valid_o && out_ready_i.
  - buf shifts left by OUT_WIDTH, zeros fill from the LSB, and fill decreases by OUT_WIDTH.
- out_data_o = buf[BUF_W-1 -: OUT_WIDTH], taken directly from the register (registered output).
- State RUN:
  - out_valid_o = (fill >= OUT_WIDTH); out_last_o = 0.
  - in_ready_o = (fill < OUT_WIDTH) || (out_ready_i && fill < 2*OUT_WIDTH). This is a combinational path from out_ready_i and guarantees no overflow (max fill 65).
  - Accept and emit in the same cycle are both applied. Fill is updated as fill - OUT_WIDTH + code_len, with the code placed after the shift.
  - Stall: while out_valid_o=1 and out_ready_i=0, in_ready_o=0, and out_data_o and fill are held stable.
  - flush_i sampled high in RUN moves the state to FLUSH. A beat accepted in the same cycle is included in the stream.
- State FLUSH:
  - in_ready_o = 0; flush_i is ignored.
  - fill >= OUT_WIDTH: emit full words, out_last_o = 1 only if fill == OUT_WIDTH.
  - 0 < fill < OUT_WIDTH: out_valid_o = 1 with the partial word (LSBs zero) and out_last_o = 1.
  - On emit of the last word, fill is set to 0 and the state moves to DONE.
  - fill == 0 on entry: no word is emitted; move to DONE on the next cycle.
- State DONE (one cycle): flush_done_o = 1, buf and fill are cleared, state returns to RUN.
- Reset is synchronous and active-high. Asserting rst at any time, including mid-stall or mid-flush, clears:
  - buf = 0, fill = 0, state = RUN.
  - out_valid_o = 0, out_last_o = 0, flush_done_o = 0.
  - out_data_o = 0.
  - in_ready_o is 1 after reset.
- code_len_i > MAX_CODE is illegal; it is clamped to MAX_CODE (simulation assertion fires).

Optional Feature:
- Macro: CODE_PACKER_STATS_EN.
- When defined, the block adds three outputs, all cleared by rst and not cleared by flush:
  - stat_codes_o (32): count of accepted beats with code_len > 0.
  - stat_bits_o (32): running sum of accepted code_len.
  - stat_words_o (32): count of emitted words.
- Counters wrap at 2^32.
- When undefined, these ports and all counting logic are absent; the behaviour of all other ports is identical.

Test Plan:
- Directed codes, then flush:
  - Stimulus: codes 0xD41, 0xD42, 0xD43 (len 12 each), then flush.
  - Words: 0xD41D42D4 (last=0), then 0x30000000 (last=1).
  - flush_done_o pulses one cycle after the last handshake.
- Sixteen zzzz codes: sixteen 2'b00 codes (len 2), with out_ready_i held at 1.
  - One word 0x00000000 is produced the cycle after the 16th accept.
  - fill returns to 0; no last flag.
- Backpressure:
  - Stimulus: two 34-bit codes of all-ones (fill 68 is not reachable; the second is accepted at fill 34 with emit) while out_ready_i=0.
  - Expect in_ready_o=0 once fill>=32, and out_data_o=0xFFFFFFFF held stable for 5 cycles.
  - On release, the word and following words drain correctly.
- Empty flush: flush_i with fill=0.
  - No out_valid_o; flush_done_o=1 exactly 2 cycles after flush_i.
  - in_ready_o=0 during FLUSH and DONE.
- Same-cycle accept and emit:
  - Stimulus: at fill=40 with out_ready_i=1, accept a len-12 code.
  - The word is emitted and the new fill is 20.
  - Bitstream matches a software packer model over 1000 random codes with random valid/ready.
- Reset mid-flush: assert rst while a partial word is pending.
  - Next cycle: out_valid_o=0, fill=0, in_ready_o=1, state RUN.
  - No flush_done_o pulse.

Source files
------------

// File: rtl/compress_code_packer.sv
// compress_code_packer: packs right-aligned variable-length codes MSB-first into OUT_WIDTH-bit words with flush; define CODE_PACKER_STATS_EN for stat counters
module compress_code_packer #(
  parameter int OUT_WIDTH = 32,
  parameter int MAX_CODE  = 34,
  parameter int LEN_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MAX_CODE-1:0]  code_i,
  input  logic [LEN_W-1:0]     code_len_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 flush_i,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_last_o,
  output logic                 flush_done_o
`ifdef CODE_PACKER_STATS_EN
  ,
  output logic [31:0]          stat_codes_o,
  output logic [31:0]          stat_bits_o,
  output logic [31:0]          stat_words_o
`endif
);
  localparam int BUF_W = OUT_WIDTH + MAX_CODE;
  localparam int FW = $clog2(BUF_W + OUT_WIDTH);
  localparam logic [FW-1:0] OW = FW'(OUT_WIDTH);
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
  state_t r_state, w_state_nxt;
  logic [BUF_W-1:0] r_buf, w_buf_nxt, w_shift, w_code;
  logic [FW-1:0] r_fill, w_fill_nxt, w_fill_sh;
  logic [LEN_W-1:0] w_len;
  logic r_valid, r_last, r_done, w_accept, w_emit;
  assign w_len = (code_len_i > LEN_W'(MAX_CODE)) ? LEN_W'(MAX_CODE) : code_len_i;
  assign in_ready_o = (r_state == RUN) && ((r_fill < OW) || (out_ready_i && r_fill < FW'(2 * OUT_WIDTH)));
  assign w_accept = in_valid_i && in_ready_o;
  assign w_emit = r_valid && out_ready_i;
  assign w_shift = w_emit ? r_buf << OUT_WIDTH : r_buf;
  assign w_fill_sh = w_emit ? r_fill - OW : r_fill;
  assign w_code = (BUF_W'(code_i) & ((BUF_W'(1) << w_len) - BUF_W'(1))) << (FW'(BUF_W) - FW'(w_len) - w_fill_sh);
  assign out_data_o = r_buf[BUF_W-1 -: OUT_WIDTH];
  assign out_valid_o = r_valid;
  assign out_last_o = r_last;
  assign flush_done_o = r_done;
  // next buffer, fill and state: the emit shift happens first, then the new code lands behind it
  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt = r_buf;
    w_fill_nxt = r_fill;
    if (r_state == RUN) begin
      w_buf_nxt = w_accept ? (w_shift | w_code) : w_shift;
      w_fill_nxt = w_fill_sh + (w_accept ? FW'(w_len) : '0);
      w_state_nxt = flush_i ? FLUSH : RUN;
    end else if (r_state == FLUSH) begin
      w_buf_nxt = (r_fill == '0 || (w_emit && r_last)) ? '0 : w_shift;
      w_fill_nxt = (r_fill == '0 || (w_emit && r_last)) ? '0 : w_fill_sh;
      w_state_nxt = (r_fill == '0 || (w_emit && r_last)) ? DONE : FLUSH;
    end else begin
      w_buf_nxt = '0;
      w_fill_nxt = '0;
      w_state_nxt = RUN;
    end
  end
  // state registers; handshake flags are registered from the next-state values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_buf <= '0;
      r_fill <= '0;
      r_valid <= 1'b0;
      r_last <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_buf <= w_buf_nxt;
      r_fill <= w_fill_nxt;
      r_valid <= (w_state_nxt == RUN) ? (w_fill_nxt >= OW) : (w_state_nxt == FLUSH && w_fill_nxt != '0);
      r_last <= (w_state_nxt == FLUSH) && (w_fill_nxt != '0) && (w_fill_nxt <= OW);
      r_done <= (w_state_nxt == DONE);
    end
  end
  assert property (@(posedge clk) disable iff (rst) in_valid_i |-> code_len_i <= LEN_W'(MAX_CODE));
`ifdef CODE_PACKER_STATS_EN
  logic [31:0] r_codes, r_bits, r_words;
  assign stat_codes_o = r_codes;
  assign stat_bits_o = r_bits;
  assign stat_words_o = r_words;
  // throughput counters survive flushes and wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_codes <= '0;
      r_bits <= '0;
      r_words <= '0;
    end else begin
      r_codes <= r_codes + 32'(w_accept && w_len != '0);
      r_bits <= r_bits + (w_accept ? 32'(w_len) : 32'd0);
      r_words <= r_words + 32'(w_emit);
    end
  end
`endif
endmodule
